// File: rtl/uart_led_pkg.sv
// rtl/uart_led_pkg.sv - shared constants for the UART LED command parser
package uart_led_pkg;

  // Frame markers and response codes
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Command codes (contiguous range SET..READ)
  localparam logic [7:0] CMD_SET  = 8'h01;
  localparam logic [7:0] CMD_OR   = 8'h02;
  localparam logic [7:0] CMD_CLR  = 8'h03;
  localparam logic [7:0] CMD_TOG  = 8'h04;
  localparam logic [7:0] CMD_READ = 8'h05;

  // Parser FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ARG  = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_EXEC = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

endpackage

// File: rtl/uart_led_timeout.sv
// rtl/uart_led_timeout.sv - inter-byte timeout counter with clear and expire pulse
module uart_led_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk_50Mhz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // A byte arriving in the expiry cycle wins, so clr masks the pulse
  assign expire = en && !clr && (cnt == LAST);

  // Count idle cycles while enabled; reload to zero on clear or expiry
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_led_cmd.sv
// rtl/uart_led_cmd.sv - 4-byte frame parser driving an LED register with byte responses
module uart_led_cmd
  import uart_led_pkg::*;
#(
  parameter int LED_W       = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [LED_W-1:0] led,
  output logic [7:0]       err_cnt
);

  logic [2:0]       state;
  logic [7:0]       cmd_q;
  logic [7:0]       arg_q;
  logic [7:0]       chk_q;
  logic [7:0]       resp_q;
  logic             in_frame;
  logic             tmo_expire;
  logic             frame_ok;
  logic [LED_W-1:0] arg_l;
  logic [LED_W-1:0] led_nxt;
  logic [7:0]       resp_nxt;
  logic [7:0]       led_ext;
  logic             err_inc;

  assign in_frame = (state == ST_CMD) || (state == ST_ARG) || (state == ST_CHK);
  assign arg_l    = arg_q[LED_W-1:0];
  assign frame_ok = (chk_q == (cmd_q ^ arg_q)) && (cmd_q >= CMD_SET) && (cmd_q <= CMD_READ);

  uart_led_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_50Mhz(clk_50Mhz),
    .rst      (rst),
    .en       (in_frame),
    .clr      (rx_ready || !in_frame),
    .expire   (tmo_expire)
  );

  // Command execution: next LED value and the response byte for the latched frame
  always_comb begin
    led_nxt  = led;
    resp_nxt = NAK;
    led_ext  = '0;
    led_ext[LED_W-1:0] = led;
    if (frame_ok) begin
      case (cmd_q)
        CMD_SET: led_nxt = arg_l;
        CMD_OR:  led_nxt = led | arg_l;
        CMD_CLR: led_nxt = led & ~arg_l;
        CMD_TOG: led_nxt = led ^ arg_l;
        default: led_nxt = led;
      endcase
      resp_nxt = (cmd_q == CMD_READ) ? led_ext : ACK;
    end
  end

  // Frame sequencing, LED update and transmit handshake
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      arg_q    <= '0;
      chk_q    <= '0;
      resp_q   <= '0;
      led      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_ready && (rx_data == SOF)) state <= ST_CMD;
        end
        ST_CMD: begin
          if (rx_ready) begin
            cmd_q <= rx_data;
            state <= ST_ARG;
          end else if (tmo_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_ARG: begin
          if (rx_ready) begin
            arg_q <= rx_data;
            state <= ST_CHK;
          end else if (tmo_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_CHK: begin
          if (rx_ready) begin
            chk_q <= rx_data;
            state <= ST_EXEC;
          end else if (tmo_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          led    <= led_nxt;
          resp_q <= resp_nxt;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= resp_q;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Dropped bytes, timeouts and rejected frames share one increment per cycle
  assign err_inc = (rx_ready && ((state == ST_EXEC) || (state == ST_RESP)))
                 || tmo_expire
                 || ((state == ST_EXEC) && !frame_ok);

  // Saturating error counter
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/uart_led_cmd.md
# uart_led_cmd

Byte-level command parser sitting directly downstream of the UART receiver and upstream of the UART transmitter in the full-duplex UART LED design. It consumes the receiver's one-cycle `rx_ready` strobe and data byte, assembles 4-byte frames (SOF, CMD, ARG, CHK), and checks the XOR checksum. Valid commands are applied to an LED register. Every completed frame produces one response byte, handed to the transmitter through a start/busy handshake.

## Interface
- `LED_W`, default 8: LED register width, 1..8; `ARG[LED_W-1:0]` is used.
- `TIMEOUT_CYC`, default 500000: max clk cycles between bytes inside a frame (10 ms at 50 MHz).
- `clk_50Mhz`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: reset, asynchronous, active-high.
- `rx_ready`, input, 1: receiver strobe; `rx_data` valid this cycle only.
- `rx_data`, input, 8: received byte.
- `tx_busy`, input, 1: transmitter busy; start is not issued while high.
- `tx_start`, output, 1: one-cycle request to send `tx_data`.
- `tx_data`, output, 8: response byte, held until the next `tx_start`.
- `led`, output, LED_W: LED register.
- `err_cnt`, output, 8: saturating count of rejected or aborted frames and dropped bytes.

## Operation
- FSM states: IDLE, CMD, ARG, CHK, EXEC, RESP.
- **IDLE**
  - On `rx_ready` with byte 0xA5: go to CMD.
  - Any other byte is ignored silently, with no `err_cnt` change.
- **CMD / ARG / CHK**
  - On `rx_ready`, latch the byte and advance to the next state: CMD→ARG→CHK→EXEC.
  - Timeout counter clears on every accepted byte.
  - If the counter reaches TIMEOUT_CYC-1 without a byte: go to IDLE, `err_cnt`+1, no response.
- **EXEC**
  - Valid frame condition: CHK == CMD ^ ARG, and CMD is one of 0x01..0x05.
  - 0x01 SET: `led`=ARG.
  - 0x02 OR: `led`|=ARG.
  - 0x03 CLR: `led`&=~ARG.
  - 0x04 TOG: `led`^=ARG.
  - 0x05 READ: `led` unchanged.
  - Response for 0x01–0x04: ACK 0x06.
  - Response for READ: the zero-extended value of `led` before EXEC.
  - Bad checksum or unknown CMD: `led` unchanged, response NAK 0x15, `err_cnt`+1.
  - Always go to RESP.
- **RESP**
  - Wait while `tx_busy`=1.
  - When `tx_busy`=0: register `tx_start`=1 and `tx_data`=response, then go to IDLE.
- Any `rx_ready` in EXEC or RESP: byte dropped, `err_cnt`+1.
- `err_cnt` saturates at 255.
- If two increments coincide in one cycle, count +1 only.

## Timing
- Reset values: state IDLE, `led`=0, `tx_start`=0, `tx_data`=0x00, `err_cnt`=0, timeout counter 0.
- Reset mid-frame or mid-RESP aborts immediately; no `tx_start` is issued.
- CHK strobe in cycle N:
  - EXEC occupies cycle N+1.
  - `led` shows the new value at N+2.
  - With `tx_busy`=0, `tx_start` is high exactly in cycle N+3.
- `tx_start` is high for exactly one cycle per frame and never while `tx_busy`=1 was sampled in the same cycle.
- `tx_data` changes only in the cycle `tx_start` asserts.
- The FSM is in IDLE during the `tx_start` cycle, so a SOF strobe in that same cycle is accepted.
- Timeout counter width: clog2(TIMEOUT_CYC). It does not count in IDLE, EXEC or RESP.
- `led` and `err_cnt` are registered; no combinational path from inputs to any output.

## Structure
- Shared package `uart_led_pkg`:
  - SOF (0xA5), ACK (0x06), NAK (0x15).
  - Command codes CMD_SET..CMD_READ.
  - FSM state encoding.
- One natural sub-module: `uart_led_timeout`, a loadable inter-byte timeout counter with clear and expire pulse.
- Command execution stays inline.

## Test plan
- Frame A5 01 3C 3D, `tx_busy`=0 → `led`=0x3C at N+2; `tx_start` at N+3 with `tx_data`=0x06; `err_cnt`=0.
- `led`=0x3C, frame A5 04 0F 0B, then A5 05 00 05 → `led`=0x33; responses 0x06 then 0x33.
- Frame A5 02 F0 00 (bad CHK) → `led` unchanged, `tx_data`=0x15, `err_cnt`=1. Frame A5 07 00 07 (unknown CMD) → NAK, `err_cnt`=2.
- A5 01, then no byte for TIMEOUT_CYC cycles → IDLE, no `tx_start`, `err_cnt`+1. A following valid frame executes normally.
- `tx_busy` held high for 1000 cycles after a valid frame → `tx_start` first asserted the cycle after `tx_busy` falls. An `rx_ready` during the wait → `err_cnt`+1, byte dropped.
- Async `rst` pulse after A5 01 → all outputs at reset values. Garbage bytes 00 FF 11 in IDLE → no response, `err_cnt` unchanged.
